// File: rtl/disk_dma_pkg.sv
// Shared types and constants for the disk DMA sequencer: FSM state encoding,
// transfer direction codes and disk geometry widths.
package disk_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRIME,
        ST_STORE,
        ST_DONE
    } dma_state_t;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    localparam int unsigned SECTOR_WORDS = 128;

    localparam int unsigned TRACK_W     = 3;
    localparam int unsigned SECTOR_W    = 5;
    localparam int unsigned DISK_ADDR_W = 7;
    localparam int unsigned DATA_W      = 32;

endpackage

// File: rtl/disk_dma_sequencer_if.sv
// Disk-controller and RAM bus driven by the DMA sequencer.
// master: the sequencer; slave: the disk controller / RAM side.
interface disk_dma_sequencer_if #(
    parameter int unsigned MEM_ADDR_W = 10
);
    import disk_dma_pkg::*;

    logic [TRACK_W-1:0]     disk_track;
    logic [SECTOR_W-1:0]    disk_sector;
    logic [DISK_ADDR_W-1:0] disk_addr;
    logic                   disk_read;
    logic                   disk_write;
    logic [DATA_W-1:0]      disk_wdata;
    logic [DATA_W-1:0]      disk_rdata;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic                   mem_we;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    modport master (
        output disk_track, disk_sector, disk_addr, disk_read, disk_write, disk_wdata,
        output mem_addr, mem_we, mem_wdata,
        input  disk_rdata, mem_rdata
    );

    modport slave (
        input  disk_track, disk_sector, disk_addr, disk_read, disk_write, disk_wdata,
        input  mem_addr, mem_we, mem_wdata,
        output disk_rdata, mem_rdata
    );

endinterface

// File: rtl/disk_dma_addr_gen.sv
// Address generation for the disk DMA sequencer: word index within the sector,
// wrapping RAM address pointer, count decode (0 means a full sector) and the
// last-word flag.
module disk_dma_addr_gen import disk_dma_pkg::*; #(
    parameter int unsigned MEM_ADDR_W   = 10,
    parameter int unsigned SECTOR_WORDS = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   adv_idx,
    input  logic                   adv_mem,
    input  logic [MEM_ADDR_W-1:0]  base,
    input  logic [DISK_ADDR_W-1:0] count,
    output logic [DISK_ADDR_W-1:0] index,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic                   last
);

    logic [DISK_ADDR_W:0] count_eff;
    logic [DISK_ADDR_W:0] count_q;

    // A zero count selects a whole sector.
    always_comb begin
        count_eff = (count == '0) ? 8'(SECTOR_WORDS) : {1'b0, count};
    end

    // Last word of the transfer is the one whose index equals count-1.
    always_comb begin
        last = ({1'b0, index} == (count_q - 8'd1));
    end

    // Index and RAM pointer: loaded on an accepted command, advanced per word.
    // The RAM pointer wraps naturally at 2**MEM_ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index    <= '0;
            mem_addr <= '0;
            count_q  <= '0;
        end else if (load) begin
            index    <= '0;
            mem_addr <= base;
            count_q  <= count_eff;
        end else begin
            if (adv_idx) index    <= index + 7'd1;
            if (adv_mem) mem_addr <= mem_addr + 1'b1;
        end
    end

endmodule

// File: rtl/disk_dma_sequencer.sv
// Disk DMA sequencer: moves up to one sector of 32-bit words between the disk
// controller and RAM, one word per cycle, after a single start pulse.
// Optional running checksum of transferred words: define DISK_DMA_CHECKSUM_EN.
module disk_dma_sequencer import disk_dma_pkg::*; #(
    parameter int unsigned MEM_ADDR_W   = 10,
    parameter int unsigned SECTOR_WORDS = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   dir,
    input  logic [TRACK_W-1:0]     cmd_track,
    input  logic [SECTOR_W-1:0]    cmd_sector,
    input  logic [MEM_ADDR_W-1:0]  cmd_mem_base,
    input  logic [DISK_ADDR_W-1:0] cmd_count,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      checksum,
    disk_dma_sequencer_if.master   bus
);

    dma_state_t             state;
    logic [TRACK_W-1:0]     track_q;
    logic [SECTOR_W-1:0]    sector_q;
    logic                   rd_q;
    logic                   wr_q;
    logic                   we_q;
    logic                   accept;
    logic                   adv_idx;
    logic                   adv_mem;
    logic                   last;
    logic [DISK_ADDR_W-1:0] index;

    // Command acceptance and per-state address stepping.
    always_comb begin
        accept  = (state == ST_IDLE) && start;
        adv_idx = (state == ST_LOAD) || (state == ST_STORE);
        adv_mem = adv_idx || (state == ST_PRIME);
    end

    disk_dma_addr_gen #(
        .MEM_ADDR_W   (MEM_ADDR_W),
        .SECTOR_WORDS (SECTOR_WORDS)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .adv_idx  (adv_idx),
        .adv_mem  (adv_mem),
        .base     (cmd_mem_base),
        .count    (cmd_count),
        .index    (index),
        .mem_addr (bus.mem_addr),
        .last     (last)
    );

    // Transfer sequencing FSM with registered status and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            we_q     <= 1'b0;
            track_q  <= '0;
            sector_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        track_q  <= cmd_track;
                        sector_q <= cmd_sector;
                        busy     <= 1'b1;
                        if (dir == DIR_LOAD) begin
                            state <= ST_LOAD;
                            rd_q  <= 1'b1;
                            we_q  <= 1'b1;
                        end else begin
                            state <= ST_PRIME;
                        end
                    end
                end
                ST_LOAD: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rd_q  <= 1'b0;
                        we_q  <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    state <= ST_STORE;
                    wr_q  <= 1'b1;
                end
                ST_STORE: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        wr_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bus drive; data paths are pass-throughs gated to zero outside their phase.
    always_comb begin
        bus.disk_track  = track_q;
        bus.disk_sector = sector_q;
        bus.disk_addr   = index;
        bus.disk_read   = rd_q;
        bus.disk_write  = wr_q;
        bus.mem_we      = we_q;
        bus.mem_wdata   = (state == ST_LOAD)  ? bus.disk_rdata : '0;
        bus.disk_wdata  = (state == ST_STORE) ? bus.mem_rdata  : '0;
    end

`ifdef DISK_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Running modulo-2**32 sum of every word moved; cleared on each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (state == ST_LOAD) begin
            csum_q <= csum_q + bus.disk_rdata;
        end else if (state == ST_STORE) begin
            csum_q <= csum_q + bus.mem_rdata;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule
